// File: rtl/cdb_driver_pkg.sv
// Shared out-of-order core configuration and the CDB result record used by
// the writeback-side CDB driver and its per-FU result queues.
package ooo_config;

  localparam int FUNC_UNITS = 4;
  localparam int CDB_LANES  = 2;
  localparam int FIFO_DEPTH = 2;
  localparam int PHYS_BITS  = 6;
  localparam int ROB_BITS   = 5;
  localparam int BRU_COUNT  = 4;
  localparam int BRU_BITS   = 2;

  typedef struct packed {
    logic                 live;
    logic [PHYS_BITS-1:0] pd;
    logic [31:0]          data;
    logic [ROB_BITS-1:0]  rob;
    logic [BRU_COUNT-1:0] bmask;
  } cdb_result_t;

  // Branch resolution applied to a single result: a mispredict kills results
  // that depend on the resolving branch, a correct predict drops the dependency.
  function automatic cdb_result_t apply_branch(input cdb_result_t  entry,
                                               input logic         flush,
                                               input logic         clr,
                                               input logic [BRU_BITS-1:0] idx);
    cdb_result_t res;
    res = entry;
    if (flush && entry.bmask[idx]) res.live = 1'b0;
    if (clr) res.bmask[idx] = 1'b0;
    return res;
  endfunction

endpackage

// File: rtl/cdb_driver_if.sv
// Bundle of FU result inputs, branch-resolve inputs and CDB broadcast lanes.
// The master side is the FU/branch/consumer environment, the slave side is
// the CDB driver.
interface cdb_driver_if
  import ooo_config::*;
#(
  parameter int N_FU    = FUNC_UNITS,
  parameter int N_LANES = CDB_LANES
) ();

  logic [N_FU-1:0]                 fu_valid;
  logic [N_FU-1:0]                 fu_ready;
  logic [N_FU-1:0][PHYS_BITS-1:0]  fu_pd;
  logic [N_FU-1:0][31:0]           fu_data;
  logic [N_FU-1:0][ROB_BITS-1:0]   fu_rob;
  logic [N_FU-1:0][BRU_COUNT-1:0]  fu_bmask;

  logic                            br_valid;
  logic                            br_mispred;
  logic [BRU_BITS-1:0]             br_idx;

  logic [N_LANES-1:0]                cdb_valid;
  logic [N_LANES-1:0][PHYS_BITS-1:0] cdb_pd;
  logic [N_LANES-1:0][31:0]          cdb_data;
  logic [N_LANES-1:0][ROB_BITS-1:0]  cdb_rob;

  modport master (
    output fu_valid, fu_pd, fu_data, fu_rob, fu_bmask,
    output br_valid, br_mispred, br_idx,
    input  fu_ready,
    input  cdb_valid, cdb_pd, cdb_data, cdb_rob
  );

  modport slave (
    input  fu_valid, fu_pd, fu_data, fu_rob, fu_bmask,
    input  br_valid, br_mispred, br_idx,
    output fu_ready,
    output cdb_valid, cdb_pd, cdb_data, cdb_rob
  );

endinterface

// File: rtl/cdb_driver_result_fifo.sv
// Per-FU result queue. Entries are killed/cleared in place on branch
// resolution, and a freshly written entry only becomes visible at the head
// one cycle after it was written, which gives the 2-cycle accept-to-broadcast
// latency through the registered CDB lanes.
module cdb_result_fifo
  import ooo_config::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enq_valid,
  input  cdb_result_t         enq_entry,
  input  logic                pop,
  input  logic                flush,
  input  logic                clr,
  input  logic [BRU_BITS-1:0] br_idx,
  output logic                ready,
  output logic                head_valid,
  output cdb_result_t         head
);

  localparam int PTR_BITS = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_BITS = PTR_BITS + 1;

  cdb_result_t         mem_q [DEPTH];
  cdb_result_t         mem_d [DEPTH];
  cdb_result_t         in_entry;
  logic [PTR_BITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_BITS-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_BITS-1:0] count_q, count_d;
  logic                fresh_q, fresh_d;
  logic                push;
  logic                do_pop;

  assign ready      = (count_q != CNT_BITS'(DEPTH));
  assign push       = enq_valid & ready;
  assign head_valid = fresh_q ? (count_q > CNT_BITS'(1)) : (count_q != '0);
  assign do_pop     = pop & head_valid;
  assign head       = mem_q[rd_ptr_q];

  // Next-state: branch kill/clear on stored and incoming entries, then push/pop.
  always_comb begin
    in_entry = apply_branch(enq_entry, flush, clr, br_idx);
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = apply_branch(mem_q[i], flush, clr, br_idx);
    end
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    fresh_d  = push;
    if (push) begin
      mem_d[wr_ptr_q] = in_entry;
      wr_ptr_d        = wr_ptr_q + PTR_BITS'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_BITS'(1);
    end
    case ({push, do_pop})
      2'b10:   count_d = count_q + CNT_BITS'(1);
      2'b01:   count_d = count_q - CNT_BITS'(1);
      default: count_d = count_q;
    endcase
  end

  // Queue state register with synchronous reset discarding all entries.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      fresh_q  <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      fresh_q  <= fresh_d;
    end
  end

endmodule

// File: rtl/cdb_driver.sv
// Writeback-side CDB producer: buffers FU results in per-FU queues,
// round-robin arbitrates up to CDB_LANES broadcasts per cycle and drives
// registered CDB lanes. Dead queue heads drain without using a lane.
module cdb_driver
  import ooo_config::cdb_result_t, ooo_config::BRU_BITS;
#(
  parameter int FUNC_UNITS = ooo_config::FUNC_UNITS,
  parameter int CDB_LANES  = ooo_config::CDB_LANES,
  parameter int FIFO_DEPTH = ooo_config::FIFO_DEPTH
) (
  input logic         clk,
  input logic         rst,
  cdb_driver_if.slave bus
);

  localparam int RR_BITS = (FUNC_UNITS > 1) ? $clog2(FUNC_UNITS) : 1;

  logic                   flush;
  logic                   clr;
  logic [FUNC_UNITS-1:0]  fu_ready;
  logic [FUNC_UNITS-1:0]  head_valid;
  logic [FUNC_UNITS-1:0]  candidate;
  logic [FUNC_UNITS-1:0]  dead;
  logic [FUNC_UNITS-1:0]  grant;
  logic [FUNC_UNITS-1:0]  pop;
  cdb_result_t            head    [FUNC_UNITS];
  cdb_result_t            enq     [FUNC_UNITS];
  logic [RR_BITS-1:0]     rr_ptr_q, rr_ptr_d;
  logic [CDB_LANES-1:0]   cdb_valid_q, cdb_valid_d;
  cdb_result_t            lane_q  [CDB_LANES];
  cdb_result_t            lane_d  [CDB_LANES];
  int                     lanes_used;
  int                     scan_idx;

  assign flush = bus.br_valid & bus.br_mispred;
  assign clr   = bus.br_valid & ~bus.br_mispred;
  assign bus.fu_ready = fu_ready;
  assign pop   = grant | dead;

  for (genvar g = 0; g < FUNC_UNITS; g++) begin : g_fu
    assign enq[g].live  = 1'b1;
    assign enq[g].pd    = bus.fu_pd[g];
    assign enq[g].data  = bus.fu_data[g];
    assign enq[g].rob   = bus.fu_rob[g];
    assign enq[g].bmask = bus.fu_bmask[g];

    cdb_result_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .enq_valid  (bus.fu_valid[g]),
      .enq_entry  (enq[g]),
      .pop        (pop[g]),
      .flush      (flush),
      .clr        (clr),
      .br_idx     (bus.br_idx),
      .ready      (fu_ready[g]),
      .head_valid (head_valid[g]),
      .head       (head[g])
    );
  end

  for (genvar l = 0; l < CDB_LANES; l++) begin : g_lane
    assign bus.cdb_pd[l]   = lane_q[l].pd;
    assign bus.cdb_data[l] = lane_q[l].data;
    assign bus.cdb_rob[l]  = lane_q[l].rob;
  end
  assign bus.cdb_valid = cdb_valid_q;

  // Classify each visible head: live and not being killed right now, or dead.
  always_comb begin
    candidate = '0;
    dead      = '0;
    for (int i = 0; i < FUNC_UNITS; i++) begin
      candidate[i] = head_valid[i] & head[i].live & ~(flush & head[i].bmask[bus.br_idx]);
      dead[i]      = head_valid[i] & ~head[i].live;
    end
  end

  // Round-robin scan from rr_ptr; the m-th granted head drives lane m.
  always_comb begin
    grant       = '0;
    rr_ptr_d    = rr_ptr_q;
    cdb_valid_d = '0;
    lanes_used  = 0;
    scan_idx    = 0;
    for (int l = 0; l < CDB_LANES; l++) lane_d[l] = '0;
    for (int j = 0; j < FUNC_UNITS; j++) begin
      scan_idx = (int'(rr_ptr_q) + j) % FUNC_UNITS;
      if (candidate[scan_idx] && (lanes_used < CDB_LANES)) begin
        grant[scan_idx]         = 1'b1;
        cdb_valid_d[lanes_used] = 1'b1;
        lane_d[lanes_used]      = head[scan_idx];
        lanes_used              = lanes_used + 1;
        rr_ptr_d                = RR_BITS'((scan_idx + 1) % FUNC_UNITS);
      end
    end
  end

  // Registered CDB lanes and round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q    <= '0;
      cdb_valid_q <= '0;
      for (int l = 0; l < CDB_LANES; l++) lane_q[l] <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      cdb_valid_q <= cdb_valid_d;
      for (int l = 0; l < CDB_LANES; l++) lane_q[l] <= lane_d[l];
    end
  end

endmodule

// File: tb/tb_cdb_driver.sv
// Directed self-checking bench for cdb_driver: a 2-lane instance for the
// main scenarios and a 1-lane instance for the back-pressure scenario.
module tb_cdb_driver;
  import ooo_config::*;

  logic clk = 1'b0;
  logic rst;
  int   compared   = 0;
  int   mismatched = 0;

  always #5 clk = ~clk;

  cdb_driver_if #(.N_FU(4), .N_LANES(2)) bus  ();
  cdb_driver_if #(.N_FU(4), .N_LANES(1)) bus1 ();

  cdb_driver #(.FUNC_UNITS(4), .CDB_LANES(2), .FIFO_DEPTH(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  cdb_driver #(.FUNC_UNITS(4), .CDB_LANES(1), .FIFO_DEPTH(2)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  int seen   [64];
  bit issued [64];
  int cur_pd [4];
  bit acc    [4];
  int next_pd;
  int acc_total;
  int bcast_total;

  task automatic check_output(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.fu_valid   = '0;
    bus.fu_pd      = '0;
    bus.fu_data    = '0;
    bus.fu_rob     = '0;
    bus.fu_bmask   = '0;
    bus.br_valid   = 1'b0;
    bus.br_mispred = 1'b0;
    bus.br_idx     = '0;
    bus1.fu_valid   = '0;
    bus1.fu_pd      = '0;
    bus1.fu_data    = '0;
    bus1.fu_rob     = '0;
    bus1.fu_bmask   = '0;
    bus1.br_valid   = 1'b0;
    bus1.br_mispred = 1'b0;
    bus1.br_idx     = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset then idle
    do_reset();
    check_output("reset_cdb_valid", 64'(bus.cdb_valid), 64'h0);
    check_output("reset_fu_ready", 64'(bus.fu_ready), 64'hF);
    check_output("reset_rr_ptr", 64'(dut.rr_ptr_q), 64'h0);
    check_output("reset_cdb_pd0", 64'(bus.cdb_pd[0]), 64'h0);
    check_output("reset_lane1_valid", 64'(bus1.cdb_valid), 64'h0);

    // Single result from FU2
    bus.fu_valid[2] = 1'b1;
    bus.fu_pd[2]    = 6'd5;
    bus.fu_data[2]  = 32'hDEADBEEF;
    bus.fu_rob[2]   = 5'd3;
    tick();
    idle_inputs();
    check_output("single_e0_valid", 64'(bus.cdb_valid), 64'h0);
    tick();
    check_output("single_e1_valid", 64'(bus.cdb_valid), 64'h0);
    tick();
    check_output("single_e2_valid", 64'(bus.cdb_valid), 64'h1);
    check_output("single_e2_pd", 64'(bus.cdb_pd[0]), 64'd5);
    check_output("single_e2_data", 64'(bus.cdb_data[0]), 64'hDEADBEEF);
    check_output("single_e2_rob", 64'(bus.cdb_rob[0]), 64'd3);
    check_output("single_e2_lane1_pd", 64'(bus.cdb_pd[1]), 64'h0);
    check_output("single_e2_rr_ptr", 64'(dut.rr_ptr_q), 64'd3);
    tick();
    check_output("single_e3_valid", 64'(bus.cdb_valid), 64'h0);

    // Contention and rotation
    do_reset();
    for (int i = 0; i < 4; i++) begin
      bus.fu_valid[i] = 1'b1;
      bus.fu_pd[i]    = 6'(10 + i);
      bus.fu_rob[i]   = 5'(i);
    end
    tick();
    idle_inputs();
    tick();
    check_output("contend_e1_valid", 64'(bus.cdb_valid), 64'h0);
    tick();
    check_output("contend_e2_valid", 64'(bus.cdb_valid), 64'h3);
    check_output("contend_e2_pd0", 64'(bus.cdb_pd[0]), 64'd10);
    check_output("contend_e2_pd1", 64'(bus.cdb_pd[1]), 64'd11);
    check_output("contend_e2_rr_ptr", 64'(dut.rr_ptr_q), 64'd2);
    tick();
    check_output("contend_e3_valid", 64'(bus.cdb_valid), 64'h3);
    check_output("contend_e3_pd0", 64'(bus.cdb_pd[0]), 64'd12);
    check_output("contend_e3_pd1", 64'(bus.cdb_pd[1]), 64'd13);
    check_output("contend_e3_rr_ptr", 64'(dut.rr_ptr_q), 64'd0);
    tick();
    check_output("contend_e4_valid", 64'(bus.cdb_valid), 64'h0);

    // Back-pressure on the single-lane instance
    do_reset();
    for (int p = 0; p < 64; p++) begin
      seen[p]   = 0;
      issued[p] = 1'b0;
    end
    next_pd     = 1;
    acc_total   = 0;
    bcast_total = 0;
    for (int i = 0; i < 4; i++) begin
      cur_pd[i]         = next_pd;
      next_pd           = next_pd + 1;
      bus1.fu_valid[i]  = 1'b1;
      bus1.fu_pd[i]     = 6'(cur_pd[i]);
    end
    for (int cyc = 0; cyc < 8; cyc++) begin
      for (int i = 0; i < 4; i++) acc[i] = bus1.fu_valid[i] & bus1.fu_ready[i];
      tick();
      if (bus1.cdb_valid[0]) begin
        seen[bus1.cdb_pd[0]]++;
        bcast_total++;
      end
      if (cyc == 0) check_output("bp_ready1_after_1", 64'(bus1.fu_ready[1]), 64'h1);
      if (cyc == 1) check_output("bp_ready1_after_2", 64'(bus1.fu_ready[1]), 64'h0);
      for (int i = 0; i < 4; i++) begin
        if (acc[i]) begin
          issued[cur_pd[i]] = 1'b1;
          acc_total++;
          cur_pd[i]     = next_pd;
          next_pd       = next_pd + 1;
          bus1.fu_pd[i] = 6'(cur_pd[i]);
        end
      end
    end
    bus1.fu_valid = '0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      tick();
      if (bus1.cdb_valid[0]) begin
        seen[bus1.cdb_pd[0]]++;
        bcast_total++;
      end
    end
    for (int p = 0; p < 64; p++) begin
      check_output($sformatf("bp_pd%0d_count", p), 64'(seen[p]), issued[p] ? 64'd1 : 64'd0);
    end
    check_output("bp_total_broadcasts", 64'(bcast_total), 64'(acc_total));
    check_output("bp_ready_drained", 64'(bus1.fu_ready), 64'hF);

    // Mispredict kill
    do_reset();
    bus.fu_valid[0] = 1'b1;
    bus.fu_pd[0]    = 6'd20;
    bus.fu_bmask[0] = 4'b0010;
    tick();
    idle_inputs();
    bus.fu_valid[0] = 1'b1;
    bus.fu_pd[0]    = 6'd21;
    bus.fu_bmask[0] = 4'b0000;
    bus.fu_valid[3] = 1'b1;
    bus.fu_pd[3]    = 6'd23;
    bus.fu_bmask[3] = 4'b0010;
    bus.br_valid    = 1'b1;
    bus.br_mispred  = 1'b1;
    bus.br_idx      = 2'd1;
    check_output("kill_fu3_ready", 64'(bus.fu_ready[3]), 64'h1);
    tick();
    idle_inputs();
    check_output("kill_b0_valid", 64'(bus.cdb_valid), 64'h0);
    tick();
    check_output("kill_b1_valid", 64'(bus.cdb_valid), 64'h0);
    tick();
    check_output("kill_b2_valid", 64'(bus.cdb_valid), 64'h1);
    check_output("kill_b2_pd", 64'(bus.cdb_pd[0]), 64'd21);
    check_output("kill_b2_ready", 64'(bus.fu_ready), 64'hF);
    tick();
    check_output("kill_b3_valid", 64'(bus.cdb_valid), 64'h0);
    tick();
    check_output("kill_b4_valid", 64'(bus.cdb_valid), 64'h0);

    // Correct predict clears the dependency; later mispredict does not kill
    do_reset();
    bus.fu_valid[1] = 1'b1;
    bus.fu_pd[1]    = 6'd30;
    bus.fu_bmask[1] = 4'b0100;
    tick();
    idle_inputs();
    bus.fu_valid[2] = 1'b1;
    bus.fu_pd[2]    = 6'd31;
    bus.fu_bmask[2] = 4'b0100;
    bus.br_valid    = 1'b1;
    bus.br_mispred  = 1'b0;
    bus.br_idx      = 2'd2;
    tick();
    idle_inputs();
    bus.br_valid    = 1'b1;
    bus.br_mispred  = 1'b1;
    bus.br_idx      = 2'd2;
    tick();
    idle_inputs();
    check_output("clr_e2_valid", 64'(bus.cdb_valid), 64'h1);
    check_output("clr_e2_pd", 64'(bus.cdb_pd[0]), 64'd30);
    tick();
    check_output("clr_e3_valid", 64'(bus.cdb_valid), 64'h1);
    check_output("clr_e3_pd", 64'(bus.cdb_pd[0]), 64'd31);
    tick();
    check_output("clr_e4_valid", 64'(bus.cdb_valid), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/cdb_driver.md
Name: cdb_driver

Overview:
- Writeback-side producer of the common data bus (CDB): the transmitter end of the wakeup/broadcast protocol the reservation stations, busy list and ROB listen to.
- Accepts completed results from each functional unit and buffers them in per-FU queues.
- Round-robin arbitrates up to CDB_LANES broadcasts per cycle and drives registered CDB lanes.
- Applies branch-resolve kill and mask-clear to everything it holds.

Parameters:
- FUNC_UNITS, 4, number of functional-unit result sources
- CDB_LANES, 2, broadcast lanes per cycle (1..FUNC_UNITS)
- FIFO_DEPTH, 2, entries per FU result queue (power of 2, ≥2)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- fu_valid  in  [FUNC_UNITS]  result presented by FU i
- fu_ready  out  [FUNC_UNITS]  queue i can accept this cycle
- fu_pd  in  [FUNC_UNITS][PHYS_BITS]  destination phys reg
- fu_data  in  [FUNC_UNITS][32]  result value
- fu_rob  in  [FUNC_UNITS][ROB_BITS]  ROB index
- fu_bmask  in  [FUNC_UNITS][BRU_COUNT]  branch dependency mask
- br_valid  in  1  branch resolved this cycle
- br_mispred  in  1  resolved branch mispredicted
- br_idx  in  BRU_BITS  resolving branch slot
- cdb_valid  out  [CDB_LANES]  lane k broadcasting
- cdb_pd  out  [CDB_LANES][PHYS_BITS]  broadcast phys reg
- cdb_data  out  [CDB_LANES][32]  broadcast value
- cdb_rob  out  [CDB_LANES][ROB_BITS]  broadcast ROB index

Behaviour:
- Reset (rst high at a clk edge): all queues empty; rr_ptr=0; all cdb_* outputs 0; fu_ready all 1 from the first cycle after reset. Reset mid-operation discards all held results.
- flush = br_valid & br_mispred; clr = br_valid & !br_mispred.
- Enqueue: a result is accepted when fu_valid[i] & fu_ready[i].
  - fu_ready[i] = (count[i] != FIFO_DEPTH), computed from registered count.
  - A dequeue in the same cycle does not raise ready.
  - A stored entry is {live, pd, data, rob, bmask}.
- Incoming kill/clear:
  - On flush, an incoming result with fu_bmask[br_idx]=1 is accepted (handshake completes) but stored with live=0.
  - On clr, the incoming bmask[br_idx] is stored as 0.
- Stored kill/clear:
  - On flush, every stored entry with bmask[br_idx]=1 gets live=0.
  - On clr, bmask[br_idx] is cleared in every entry.
- Dead heads: a head with live=0 is popped with no broadcast and consumes no lane. Each queue may pop at most one entry per cycle.
- Arbitration, combinational on registered queue state:
  - Candidates are FUs whose head is live and not killed by a flush this cycle.
  - Scan in order rr_ptr, rr_ptr+1, … mod FUNC_UNITS.
  - The first CDB_LANES candidates are granted; the m-th grant drives lane m.
  - Granted heads pop.
  - If any grant is made, rr_ptr <= (last granted index + 1) mod FUNC_UNITS; otherwise rr_ptr holds.
- Output register: cdb_* <= the granted heads, one per lane; ungranted lanes get cdb_valid=0, other fields 0.
- Latency: result accepted at edge N is broadcast (cdb_valid high) in the cycle after edge N+2 at best, i.e. a 2-cycle minimum.
- A flush arriving while a result is already in the output register does not retract it. Consumers filter it by ROB/branch state.
- pd=0 results are broadcast normally, since the ROB needs completion.
- Queue pointers wrap mod FIFO_DEPTH. Enqueue and dequeue may occur in the same cycle. A full queue with a simultaneous pop still shows ready=0 that cycle.

Decomposition:
- Package ooo_config holds FUNC_UNITS, CDB_LANES, PHYS_BITS, ROB_BITS, BRU_COUNT, BRU_BITS.
- Package ooo_config also holds typedef cdb_result_t {live, pd, data, rob, bmask}.
- Sub-module cdb_result_fifo: one per FU, instantiated FUNC_UNITS times. It provides enqueue, pop, head, count, and flush/clear on br_idx.
- Arbiter and output register stay in the top module.

Test Plan:
- Reset then idle: cdb_valid=0 on both lanes, fu_ready=4'b1111, rr_ptr=0.
- Single result: FU2 result pd=5, data=0xDEADBEEF, rob=3 at edge 0 -> lane0 valid with pd=5, data=0xDEADBEEF, rob=3 in the cycle after edge 2, one cycle only. Lane1 stays invalid.
- Contention and rotation: all 4 FUs each present one result at edge 0, rr_ptr=0 -> next broadcast cycle has lanes {FU0, FU1}, the following cycle {FU2, FU3}, and rr_ptr returns to 0.
- Back-pressure:
  - Hold fu_valid[1] with CDB_LANES=1 while other FUs stream -> fu_ready[1] drops after 2 accepts.
  - No result is lost; every pd appears exactly once on the CDB.
- Mispredict kill:
  - Queue FU0 entries with bmask=4'b0010 and 4'b0000. Assert br_valid=1, br_mispred=1, br_idx=1 before broadcast.
  - Only the bmask=0 entry is broadcast.
  - An incoming masked result on the same cycle is accepted but never broadcast.
- Correct predict:
  - Entry with bmask=4'b0100; br_valid=1, br_mispred=0, br_idx=2.
  - A later mispredict with br_idx=2 does not kill it, and it is broadcast.
